// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer for a 1-cycle synchronous-read instruction memory.
// It issues fetch PCs, buffers responses in a 2-entry skid FIFO and handles execute redirects.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        misalign_fault
);

  typedef enum logic {RUN, HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        req_v_q, req_v_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        misalign_q;

  logic [31:0] fifo_pc_q    [2];
  logic [31:0] fifo_instr_q [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  count_q;

  logic        misaligned;
  logic        fifo_empty;
  logic        pop, fifo_pop, push;
  logic        issue;
  logic [2:0]  occupancy;

  if (MEM_DEPTH == 0) begin : g_bad_depth
    $error("fetch_ctrl: MEM_DEPTH must be non-zero");
  end

  assign misaligned     = (redirect_pc[1:0] != 2'b00);
  assign imem_addr      = fetch_pc_q;
  assign misalign_fault = misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) state_d = misaligned ? HALT : RUN;
  end

  // Occupancy after this cycle's pop decides whether one more read fits the FIFO.
  always_comb begin
    occupancy = {1'b0, count_q} + {2'b00, req_v_q} - {2'b00, pop};
    issue     = (state_q == RUN) && !redirect_valid && (occupancy <= 3'd1);
  end

  assign fifo_empty = (count_q == 2'd0);
  assign out_valid  = !fifo_empty || req_v_q;
  assign pop        = out_valid && out_ready;
  assign fifo_pop   = pop && !fifo_empty;
  assign push       = req_v_q && !(fifo_empty && pop);

  always_comb begin
    out_pc    = '0;
    out_instr = '0;
    if (!fifo_empty) begin
      out_pc    = fifo_pc_q[rd_ptr_q];
      out_instr = fifo_instr_q[rd_ptr_q];
    end else if (req_v_q) begin
      out_pc    = req_pc_q;
      out_instr = imem_rdata;
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_v_d    = 1'b0;
    req_pc_d   = req_pc_q;
    if (redirect_valid) begin
      if (!misaligned) fetch_pc_d = redirect_pc;
    end else if (issue) begin
      req_v_d    = 1'b1;
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      req_v_q    <= 1'b0;
      req_pc_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_v_q    <= req_v_d;
      req_pc_q   <= req_pc_d;
      misalign_q <= redirect_valid && misaligned;
    end
  end

  // A redirect flushes the FIFO; the entries are only visible through count_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (redirect_valid) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push)     wr_ptr_q <= ~wr_ptr_q;
      if (fifo_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, fifo_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push && !redirect_valid) begin
      fifo_pc_q[wr_ptr_q]    <= req_pc_q;
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl with a synchronous-read program memory model.
// Each table row is one clock cycle: the inputs driven and the outputs expected in that cycle.
module tb_fetch_ctrl;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        expValid;
    logic [31:0] expPc;
    logic        expFault;
    logic [31:0] expAddr;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        misalign_fault;

  int assertCount = 0;
  int failCount   = 0;
  vec_t vecs [32];

  fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .misalign_fault (misalign_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image: word-tagged content inside a 1024-word memory, NOP beyond it.
  function automatic logic [31:0] progWord(input logic [31:0] pc);
    if (pc < 32'h0000_1000) return 32'h5A00_0000 | pc;
    return 32'h0000_0013;
  endfunction

  always_ff @(posedge clk) imem_rdata <= progWord(imem_addr);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    out_ready      = v.rdy;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
  endtask

  task automatic checkRow(input int idx, input vec_t v);
    checkOutput($sformatf("row%0d out_valid", idx), {31'd0, out_valid}, {31'd0, v.expValid});
    checkOutput($sformatf("row%0d misalign_fault", idx), {31'd0, misalign_fault}, {31'd0, v.expFault});
    checkOutput($sformatf("row%0d imem_addr", idx), imem_addr, v.expAddr);
    if (v.expValid) begin
      checkOutput($sformatf("row%0d out_pc", idx), out_pc, v.expPc);
      checkOutput($sformatf("row%0d out_instr", idx), out_instr, progWord(v.expPc));
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, " out_pc"}, out_pc, 32'd0);
    checkOutput({tag, " out_instr"}, out_instr, 32'd0);
    checkOutput({tag, " misalign_fault"}, {31'd0, misalign_fault}, 32'd0);
    checkOutput({tag, " imem_addr"}, imem_addr, 32'd0);
  endtask

  initial begin
    //           rdy   rv    rpc            valid expPc          fault expAddr
    vecs[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0000_0004};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         1'b0, 32'h0000_0008};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         1'b0, 32'h0000_000C};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hC,         1'b0, 32'h0000_0010};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hC,         1'b0, 32'h0000_0014};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hC,         1'b0, 32'h0000_0014};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hC,         1'b0, 32'h0000_0014};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hC,         1'b0, 32'h0000_0014};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hC,         1'b0, 32'h0000_0014};
    vecs[10] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h10,        1'b0, 32'h0000_0018};
    vecs[11] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h14,        1'b0, 32'h0000_001C};
    vecs[12] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h18,        1'b0, 32'h0000_0020};
    vecs[13] = '{1'b0, 1'b1, 32'h100,       1'b1, 32'h18,        1'b0, 32'h0000_0020};
    vecs[14] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_0100};
    vecs[15] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h100,       1'b0, 32'h0000_0104};
    vecs[16] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h104,       1'b0, 32'h0000_0108};
    vecs[17] = '{1'b1, 1'b1, 32'h102,       1'b1, 32'h108,       1'b0, 32'h0000_010C};
    vecs[18] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_010C};
    vecs[19] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_010C};
    vecs[20] = '{1'b1, 1'b1, 32'h103,       1'b0, 32'h0,         1'b0, 32'h0000_010C};
    vecs[21] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_010C};
    vecs[22] = '{1'b1, 1'b1, 32'h200,       1'b0, 32'h0,         1'b0, 32'h0000_010C};
    vecs[23] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_0200};
    vecs[24] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h200,       1'b0, 32'h0000_0204};
    vecs[25] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h204,       1'b0, 32'h0000_0208};
    vecs[26] = '{1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 32'h208,       1'b0, 32'h0000_020C};
    vecs[27] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'hFFFF_FFF8};
    vecs[28] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFF8, 1'b0, 32'hFFFF_FFFC};
    vecs[29] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000};
    vecs[30] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0000_0004};
    vecs[31] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         1'b0, 32'h0000_0008};

    rst_n          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkRow(i, vecs[i]);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of a cycle while instructions are streaming.
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState("async reset");
    @(posedge clk);
    #1;
    checkResetState("reset held");
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkRow(100 + i, vecs[i]);
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
